// File: rtl/ccff_loader_pkg.sv
// Shared types and width helpers for the configuration-chain loader.
//   state_e         : controller FSM states
//   cnt_w()         : bit-counter width for a given chain length
//   words_per_pass(): host words needed to fill the chain once
//   bit_idx_w()     : word_bit counter width (minimum 1)
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        SHIFT     = 3'd2,
        NEXT_PASS = 3'd3,
        DONE      = 3'd4
    } state_e;

    function automatic int unsigned cnt_w(input int unsigned chain_len);
        return $clog2(chain_len + 1);
    endfunction

    function automatic int unsigned words_per_pass(input int unsigned chain_len,
                                                   input int unsigned word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    function automatic int unsigned bit_idx_w(input int unsigned word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host bitstream port: valid/ready word transfer into the loader.
//   cfg_data  : bitstream word, bit 0 shifted first
//   cfg_valid : host has a word
//   cfg_ready : loader accepts the word this cycle
interface ccff_chain_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input  cfg_ready);
    modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_word_serializer.sv
// Holds the current bitstream word and presents one bit per shift cycle.
//   load       : latch data and restart at bit 0
//   advance    : step to the next bit (saturates at the last bit)
//   head_en_c  : next cycle is a shift cycle; otherwise ccff_head is 0
//   ccff_head  : registered serial bit for the chain
//   last_bit_c : current bit is the top bit of the word
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter  int unsigned WORD_W = 8,
    localparam int unsigned BIT_W  = bit_idx_w(WORD_W)
) (
    input  logic              prog_clk,
    input  logic              prog_rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic              head_en_c,
    input  logic [WORD_W-1:0] data,
    output logic              ccff_head,
    output logic              last_bit_c
);

    logic [WORD_W-1:0] word;
    logic [BIT_W-1:0]  word_bit;
    logic [WORD_W-1:0] word_nxt_c;
    logic [BIT_W-1:0]  word_bit_nxt_c;

    assign last_bit_c = (word_bit == BIT_W'(WORD_W - 1));

    // Next word / bit pointer; pointer never wraps, reload restarts it.
    always_comb begin
        word_nxt_c     = word;
        word_bit_nxt_c = word_bit;
        if (load) begin
            word_nxt_c     = data;
            word_bit_nxt_c = '0;
        end else if (advance && !last_bit_c) begin
            word_bit_nxt_c = word_bit + BIT_W'(1);
        end
    end

    // Head is registered from the next pointer so it lines up with shift_en.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            word      <= '0;
            word_bit  <= '0;
            ccff_head <= 1'b0;
        end else begin
            word      <= word_nxt_c;
            word_bit  <= word_bit_nxt_c;
            ccff_head <= head_en_c & word_nxt_c[word_bit_nxt_c];
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: serialises host words onto a ccff chain with an
// optional replay pass that compares ccff_tail against ccff_head.
//   prog_clk, prog_rst_n : clock, async active-low reset
//   start, verify_en     : begin a run, verify mode sampled at start
//   abort                : synchronous abort to IDLE (highest priority)
//   cfg                  : host word port (slave side)
//   ccff_head, ccff_tail : chain serial in / out
//   shift_en             : chain clock enable, high only on valid head bits
//   busy, done           : run in progress / end-of-run pulse
//   verify_fail, fail_idx: sticky mismatch flag and first failing bit index
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter  int unsigned CHAIN_LEN = 10,
    parameter  int unsigned WORD_W    = 8,
    localparam int unsigned CNT_W     = cnt_w(CHAIN_LEN)
) (
    input  logic                    prog_clk,
    input  logic                    prog_rst_n,
    input  logic                    start,
    input  logic                    verify_en,
    input  logic                    abort,
    ccff_chain_loader_if.slave      cfg,
    output logic                    ccff_head,
    input  logic                    ccff_tail,
    output logic                    shift_en,
    output logic                    busy,
    output logic                    done,
    output logic                    verify_fail,
    output logic [CNT_W-1:0]        fail_idx
);

    state_e           state, next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic             pass;
    logic             verify_q;

    logic             last_cnt_c;
    logic             last_bit_c;
    logic             load_c;
    logic             advance_c;
    logic             head_en_c;
    logic             cfg_ready_nxt_c;
    logic             shift_en_nxt_c;
    logic             busy_nxt_c;
    logic             done_nxt_c;

    assign last_cnt_c = (bit_cnt == CNT_W'(CHAIN_LEN - 1));

    // State register.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) state <= IDLE;
        else             state <= next_state;
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (start)         next_state = FETCH;
            FETCH:     if (cfg.cfg_valid) next_state = SHIFT;
            SHIFT: begin
                if (last_cnt_c)      next_state = (!pass && verify_q) ? NEXT_PASS : DONE;
                else if (last_bit_c) next_state = FETCH;
            end
            NEXT_PASS: next_state = FETCH;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    // Output decode from next state so the registered outputs track the state.
    always_comb begin
        cfg_ready_nxt_c = 1'b0;
        shift_en_nxt_c  = 1'b0;
        busy_nxt_c      = 1'b0;
        done_nxt_c      = 1'b0;
        load_c          = 1'b0;
        advance_c       = 1'b0;
        head_en_c       = 1'b0;
        cfg_ready_nxt_c = (next_state == FETCH);
        shift_en_nxt_c  = (next_state == SHIFT);
        head_en_c       = (next_state == SHIFT);
        busy_nxt_c      = (next_state inside {FETCH, SHIFT, NEXT_PASS});
        done_nxt_c      = (next_state == DONE);
        load_c          = (state == FETCH) && cfg.cfg_valid && !abort;
        advance_c       = (state == SHIFT) && !abort;
    end

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            cfg.cfg_ready <= 1'b0;
            shift_en      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            cfg.cfg_ready <= cfg_ready_nxt_c;
            shift_en      <= shift_en_nxt_c;
            busy          <= busy_nxt_c;
            done          <= done_nxt_c;
        end
    end

    // Bit counter, pass flag and verify compare; frozen on abort.
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            bit_cnt     <= '0;
            pass        <= 1'b0;
            verify_q    <= 1'b0;
            verify_fail <= 1'b0;
            fail_idx    <= '0;
        end else if (!abort) begin
            if ((state == IDLE) && start) begin
                verify_q    <= verify_en;
                pass        <= 1'b0;
                bit_cnt     <= '0;
                verify_fail <= 1'b0;
                fail_idx    <= '0;
            end
            if (state == SHIFT) begin
                if (!last_cnt_c) bit_cnt <= bit_cnt + CNT_W'(1);
                // Only the first mismatch of the replay pass is recorded.
                if (pass && (ccff_tail != ccff_head) && !verify_fail) begin
                    verify_fail <= 1'b1;
                    fail_idx    <= bit_cnt;
                end
            end
            if (state == NEXT_PASS) begin
                pass    <= 1'b1;
                bit_cnt <= '0;
            end
        end
    end

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .load       (load_c),
        .advance    (advance_c),
        .head_en_c  (head_en_c),
        .data       (cfg.cfg_data),
        .ccff_head  (ccff_head),
        .last_bit_c (last_bit_c)
    );

endmodule
